// File: rtl/room_sequencer_pkg.sv
// Shared constants and types for the maze room sequencer: playfield bounds,
// reset position, FSM state and direction encodings.
package meikyuu_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned ROOM_W  = 2;

  localparam int unsigned X_MIN = 97;
  localparam int unsigned X_MAX = 736;
  localparam int unsigned Y_MIN = 3;
  localparam int unsigned Y_MAX = 482;

  localparam int unsigned RESET_X    = 400;
  localparam int unsigned RESET_Y    = 240;
  localparam int unsigned RESET_ROOM = 1;

  typedef enum logic [2:0] {
    IDLE,
    PROPOSE,
    CHECK,
    COMMIT,
    FADE
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

endpackage

// File: rtl/room_sequencer_if.sv
// Frame/button/wall-test handshake and position outputs of the room sequencer.
interface room_sequencer_if;
  import meikyuu_pkg::*;

  logic               frame_tick;
  logic               btn_up;
  logic               btn_down;
  logic               btn_left;
  logic               btn_right;
  logic               collision;
  logic [COORD_W-1:0] cand_x;
  logic [COORD_W-1:0] cand_y;
  logic               cand_valid;
  logic [COORD_W-1:0] x_pos;
  logic [COORD_W-1:0] y_pos;
  logic [ROOM_W-1:0]  room_x;
  logic [ROOM_W-1:0]  room_y;
  logic               transition;

  modport master (
    output frame_tick, btn_up, btn_down, btn_left, btn_right, collision,
    input  cand_x, cand_y, cand_valid, x_pos, y_pos, room_x, room_y, transition
  );

  modport slave (
    input  frame_tick, btn_up, btn_down, btn_left, btn_right, collision,
    output cand_x, cand_y, cand_valid, x_pos, y_pos, room_x, room_y, transition
  );
endinterface

// File: rtl/room_sequencer_dir_priority.sv
// Encodes the four direction buttons into one direction (up > down > left > right).
module dir_priority
  import meikyuu_pkg::*;
(
  input  logic up,
  input  logic down,
  input  logic left,
  input  logic right,
  output dir_t dir_c,
  output logic valid_c
);

  always_comb begin
    dir_c = DIR_RIGHT;
    if (up)        dir_c = DIR_UP;
    else if (down) dir_c = DIR_DOWN;
    else if (left) dir_c = DIR_LEFT;
  end

  assign valid_c = up | down | left | right;

endmodule

// File: rtl/room_sequencer.sv
// Player movement and room-change sequencer for the maze game.
// Build option: define MEIKYUU_WRAP_EN to wrap the room index at the grid border.
module room_sequencer
  import meikyuu_pkg::*;
#(
  parameter int unsigned STEP        = 2,
  parameter int unsigned SPRITE      = 16,
  parameter int unsigned FADE_FRAMES = 8,
  parameter int unsigned GRID        = 3
) (
  input logic             CLOCK_25,
  input logic             reset,
  room_sequencer_if.slave bus
);

  localparam int unsigned CAND_W = COORD_W + 1;
  localparam int unsigned FCNT_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;

  state_t                   state;
  dir_t                     dir_q;
  dir_t                     dir_c;
  logic                     dir_valid_c;
  logic signed [CAND_W-1:0] cand_x_q, cand_y_q;
  logic signed [CAND_W-1:0] next_cx_c, next_cy_c;
  logic [COORD_W-1:0]       x_q, y_q, edge_coord_c;
  logic [ROOM_W-1:0]        room_x_q, room_y_q, room_cur_c, room_next_c;
  logic                     cand_valid_q, transition_q;
  logic [FCNT_W-1:0]        fade_cnt;
  logic                     in_bounds_c, on_x_c, low_edge_c, at_border_c, can_cross_c;

  dir_priority u_dir (
    .up      (bus.btn_up),
    .down    (bus.btn_down),
    .left    (bus.btn_left),
    .right   (bus.btn_right),
    .dir_c   (dir_c),
    .valid_c (dir_valid_c)
  );

  // Candidate comes from the live buttons so it is presented the cycle after frame_tick.
  always_comb begin
    next_cx_c = $signed({1'b0, x_q});
    next_cy_c = $signed({1'b0, y_q});
    case (dir_c)
      DIR_UP:    next_cy_c = $signed({1'b0, y_q}) - $signed(CAND_W'(STEP));
      DIR_DOWN:  next_cy_c = $signed({1'b0, y_q}) + $signed(CAND_W'(STEP));
      DIR_LEFT:  next_cx_c = $signed({1'b0, x_q}) - $signed(CAND_W'(STEP));
      default:   next_cx_c = $signed({1'b0, x_q}) + $signed(CAND_W'(STEP));
    endcase
  end

  // Bounds test on the held candidate and the room step for an edge crossing.
  always_comb begin
    in_bounds_c = (int'(cand_x_q) >= int'(X_MIN)) &&
                  (int'(cand_x_q) + int'(SPRITE) <= int'(X_MAX)) &&
                  (int'(cand_y_q) >= int'(Y_MIN)) &&
                  (int'(cand_y_q) + int'(SPRITE) <= int'(Y_MAX));
    on_x_c      = (dir_q == DIR_LEFT) || (dir_q == DIR_RIGHT);
    low_edge_c  = (dir_q == DIR_LEFT) || (dir_q == DIR_UP);
    room_cur_c  = on_x_c ? room_x_q : room_y_q;
    at_border_c = low_edge_c ? (room_cur_c == '0) : (room_cur_c == ROOM_W'(GRID - 1));
    room_next_c = low_edge_c ? room_cur_c - ROOM_W'(1) : room_cur_c + ROOM_W'(1);
`ifdef MEIKYUU_WRAP_EN
    if (at_border_c) room_next_c = low_edge_c ? ROOM_W'(GRID - 1) : '0;
    can_cross_c = 1'b1;
`else
    can_cross_c = !at_border_c;
`endif
    if (on_x_c) edge_coord_c = low_edge_c ? COORD_W'(X_MAX - SPRITE) : COORD_W'(X_MIN);
    else        edge_coord_c = low_edge_c ? COORD_W'(Y_MAX - SPRITE) : COORD_W'(Y_MIN);
  end

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      dir_q        <= DIR_UP;
      cand_x_q     <= '0;
      cand_y_q     <= '0;
      cand_valid_q <= 1'b0;
      x_q          <= COORD_W'(RESET_X);
      y_q          <= COORD_W'(RESET_Y);
      room_x_q     <= ROOM_W'(RESET_ROOM);
      room_y_q     <= ROOM_W'(RESET_ROOM);
      transition_q <= 1'b0;
      fade_cnt     <= '0;
    end else begin
      cand_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.frame_tick && dir_valid_c) begin
            dir_q        <= dir_c;
            cand_x_q     <= next_cx_c;
            cand_y_q     <= next_cy_c;
            cand_valid_q <= 1'b1;
            state        <= PROPOSE;
          end
        end
        PROPOSE: state <= CHECK;
        CHECK: begin
          if (bus.collision) begin
            state <= IDLE;
          end else begin
            // Position/room land on entry to COMMIT; COMMIT then routes to FADE or IDLE.
            state <= COMMIT;
            if (in_bounds_c) begin
              x_q <= cand_x_q[COORD_W-1:0];
              y_q <= cand_y_q[COORD_W-1:0];
            end else if (can_cross_c) begin
              transition_q <= 1'b1;
              if (on_x_c) begin
                room_x_q <= room_next_c;
                x_q      <= edge_coord_c;
              end else begin
                room_y_q <= room_next_c;
                y_q      <= edge_coord_c;
              end
            end
          end
        end
        COMMIT: state <= transition_q ? FADE : IDLE;
        FADE: begin
          if (bus.frame_tick) begin
            if (fade_cnt == FCNT_W'(FADE_FRAMES - 1)) begin
              fade_cnt     <= '0;
              transition_q <= 1'b0;
              state        <= IDLE;
            end else begin
              fade_cnt <= fade_cnt + FCNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cand_x     = cand_x_q[COORD_W-1:0];
  assign bus.cand_y     = cand_y_q[COORD_W-1:0];
  assign bus.cand_valid = cand_valid_q;
  assign bus.x_pos      = x_q;
  assign bus.y_pos      = y_q;
  assign bus.room_x     = room_x_q;
  assign bus.room_y     = room_y_q;
  assign bus.transition = transition_q;

endmodule

// File: doc/room_sequencer.md
ROOM_SEQUENCER -- requirements
Module: room_sequencer

Interface
REQ-001 SHALL have parameter STEP, default 2, meaning pixels moved per accepted frame.
REQ-002 SHALL have parameter SPRITE, default 16, meaning player square size in pixels.
REQ-003 SHALL have parameter FADE_FRAMES, default 8, meaning frames of blanking on room change.
REQ-004 SHALL have parameter GRID, default 3, meaning rooms per axis of the maze grid.
REQ-005 SHALL have port CLOCK_25  in  1, meaning the single clock.
REQ-006 SHALL have port reset  in  1, meaning the reset; it is asynchronous and active-high.
REQ-007 SHALL have port frame_tick  in  1, meaning a one-cycle pulse once per frame at the start of vertical blanking.
REQ-008 SHALL have ports btn_up, btn_down, btn_left, btn_right  in  1 each, meaning active-high direction requests, already synchronous.
REQ-009 SHALL have port collision  in  1, meaning the wall test for cand_x/cand_y, valid in the cycle after cand_valid.
REQ-010 SHALL have ports cand_x, cand_y  out  10 each, meaning the candidate player position.
REQ-011 SHALL have port cand_valid  out  1, meaning cand_x/cand_y are being presented for the wall test.
REQ-012 SHALL have ports x_pos, y_pos  out  10 each, meaning the committed player position in counter coordinates.
REQ-013 SHALL have ports room_x, room_y  out  2 each, meaning the current room index.
REQ-014 SHALL have port transition  out  1, meaning high while the room-change blanking is in progress.

Function
REQ-015 SHALL implement FSM states IDLE, PROPOSE, CHECK, COMMIT, FADE.
REQ-016 IDLE: on frame_tick with any button high SHALL go to PROPOSE; with no button high SHALL stay in IDLE.
REQ-017 Direction SHALL be chosen by priority up > down > left > right, latched at frame_tick; buttons are ignored outside IDLE.
REQ-018 PROPOSE: cand = pos -/+ STEP on one axis, computed 11-bit signed; cand_valid=1 for exactly this one cycle; then go to CHECK.
REQ-019 CHECK: collision=1 SHALL discard the move and go to IDLE; otherwise go to COMMIT.
REQ-020 COMMIT, in-bounds (X_MIN <= cand_x, cand_x+SPRITE <= X_MAX, and the same for y): pos SHALL load cand; then go to IDLE.
REQ-021 COMMIT, out-of-bounds with a neighbour room present: room SHALL step by 1 toward the crossed edge; the crossed coordinate SHALL be set to the opposite edge (left edge -> X_MAX-SPRITE, right edge -> X_MIN, up edge -> Y_MAX-SPRITE, down edge -> Y_MIN); then go to FADE.
REQ-022 COMMIT, out-of-bounds at the grid border (room 0 leaving low, room GRID-1 leaving high): the move SHALL be discarded; then go to IDLE (unless WRAP_EN).
REQ-023 FADE: transition=1; SHALL count FADE_FRAMES frame_ticks, then return to IDLE with transition=0 in the cycle after the last tick.
REQ-024 Latency: frame_tick at cycle 0 -> cand_valid at cycle 1 -> collision sampled at cycle 2 -> x_pos/y_pos/room_x/room_y updated at cycle 3.
REQ-025 cand_x/cand_y SHALL hold their last value when cand_valid=0.
REQ-026 A frame_tick arriving in PROPOSE, CHECK or COMMIT SHALL be ignored.

Reset
REQ-027 Asserting reset at any time, including mid-FADE, SHALL force IDLE, x_pos=400, y_pos=240, room_x=1, room_y=1, cand_x=cand_y=0, cand_valid=0, transition=0, and clear the fade counter.

Configuration
REQ-028 With MEIKYUU_WRAP_EN defined, a border crossing SHALL wrap the room index (0 -> GRID-1, GRID-1 -> 0) and behave as REQ-021; without the macro, REQ-022 applies.

Structure
REQ-029 Package meikyuu_pkg SHALL hold X_MIN=97, X_MAX=736, Y_MIN=3, Y_MAX=482, the reset position constants, and the FSM state typedef.
REQ-030 Sub-module dir_priority SHALL encode the four buttons into a 2-bit direction plus a valid bit.

Verification
REQ-031 After reset, hold btn_right with collision=0 and apply 1 tick: x_pos=402 at cycle 3, room unchanged.
REQ-032 Hold btn_up and btn_left together with collision=1: cand_y=238 and cand_valid pulses, then pos stays at 400/240.
REQ-033 With x_pos=98 and room_x=1, press left with collision=0: room_x=0, x_pos=720, transition stays high for 8 ticks, then drops.
REQ-034 With x_pos=98 and room_x=0, press left: without MEIKYUU_WRAP_EN pos and room are unchanged; with it room_x=2 and x_pos=720.
REQ-035 Assert reset during the 4th FADE tick: all outputs return to reset values, and the next tick with btn_down gives y_pos=242.
